// File: rtl/io_address_sequencer.sv
// io_address_sequencer: emits raw I/O port addresses for a burst of consecutive port indices.
// Defining IO_ADDRESS_SEQUENCER_RANGE_CHECK_EN rejects starts that fall outside the block.
module io_address_sequencer #(
   parameter int unsigned ADDR_COUNT = 1,
   parameter int unsigned ADDR_BASE  = 0,
   parameter int unsigned ADDR_WIDTH = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_index,
   input  logic [ADDR_WIDTH:0]   length,
   output logic                  busy,
   output logic                  addr_valid,
   input  logic                  addr_ready,
   output logic [ADDR_WIDTH-1:0] raw_address,
   output logic [ADDR_WIDTH-1:0] index,
   output logic                  last,
   output logic                  done,
   output logic                  error
);

   localparam int unsigned AW = ADDR_WIDTH;
   localparam int unsigned CW = ADDR_WIDTH + 1;
   localparam logic [AW-1:0] BaseRaw   = AW'(ADDR_BASE);
   localparam logic [CW-1:0] Count     = CW'(ADDR_COUNT);
   localparam logic [AW-1:0] IndexLast = AW'(ADDR_COUNT - 1);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] index_q, index_d;
   logic [AW-1:0] raw_q, raw_d;
   logic [CW-1:0] remaining_q, remaining_d;
   logic          last_q, last_d;
   logic          done_q, done_d;
   logic          reject;
   logic [AW-1:0] load_index;

`ifdef IO_ADDRESS_SEQUENCER_RANGE_CHECK_EN
   logic [AW+1:0] end_sum;
   logic          error_q;

   assign end_sum    = {2'b00, start_index} + {1'b0, length};
   assign reject     = ({1'b0, start_index} >= Count) || (end_sum > {1'b0, Count});
   assign load_index = start_index;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         error_q <= 1'b0;
      end else begin
         error_q <= (state_q == StIdle) && start && reject;
      end
   end
`else
   assign reject     = 1'b0;
   // Out-of-block start indices fold back into the block.
   assign load_index = AW'({1'b0, start_index} % Count);
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         index_q     <= '0;
         raw_q       <= BaseRaw;
         remaining_q <= '0;
         last_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         index_q     <= index_d;
         raw_q       <= raw_d;
         remaining_q <= remaining_d;
         last_q      <= last_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      index_d     = index_q;
      raw_d       = raw_q;
      remaining_d = remaining_q;
      last_d      = last_q;
      done_d      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start && !reject) begin
               if (length == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d     = StRun;
                  index_d     = load_index;
                  raw_d       = AW'({1'b0, BaseRaw} + {1'b0, load_index});
                  remaining_d = length;
                  last_d      = (length == CW'(1));
               end
            end
         end
         StRun: begin
            if (addr_ready) begin
               remaining_d = remaining_q - CW'(1);
               last_d      = (remaining_q == CW'(2));
               // An index wrap restarts the raw address at the block base.
               if (index_q == IndexLast) begin
                  index_d = '0;
                  raw_d   = BaseRaw;
               end else begin
                  index_d = index_q + AW'(1);
                  raw_d   = AW'({1'b0, raw_q} + CW'(1));
               end
               if (last_q) begin
                  state_d = StIdle;
                  last_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy        = (state_q == StRun);
      addr_valid  = (state_q == StRun);
      raw_address = raw_q;
      index       = index_q;
      last        = last_q;
      done        = done_q;
`ifdef IO_ADDRESS_SEQUENCER_RANGE_CHECK_EN
      error       = error_q;
`else
      error       = 1'b0;
`endif
   end

endmodule
